// File: rtl/adc_conv_sched.sv
// Conversion scheduler for the shared SOL/BB ADC: holds requests, arbitrates fairly,
// issues one conversion at a time, routes results and enforces a chip-select quiet gap.
module adc_conv_sched #(
    parameter int unsigned GAP_CYCLES = 40,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic        tx_clk,
    input  logic        tx_rst_n,
    input  logic        enable,
    input  logic        sol_req,
    input  logic        bb_req,
    input  logic        clr_err,
    input  logic [11:0] adc_data,
    input  logic        adc_data_val,
    output logic        adc_convert,
    output logic        convert_slow,
    output logic [11:0] sol_data,
    output logic        sol_val,
    output logic [11:0] bb_data,
    output logic        bb_val,
    output logic        busy,
    output logic        sol_ovr,
    output logic        bb_ovr,
    output logic        timeout_err
);

    localparam int unsigned CNT_W = 10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        GAP   = 3'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              sol_pend;
    logic              bb_pend;
    logic              last_bb;
    logic              grant_bb;

    logic grant_bb_c;
    logic timeout_hit_c;
    logic gap_done_c;
    logic sol_set_c;
    logic bb_set_c;
    logic sol_clr_c;
    logic bb_clr_c;
    logic tmo_evt_c;

    // Fair arbitration: a tie goes to the channel not served last
    assign grant_bb_c    = bb_pend & (~sol_pend | ~last_bb);
    assign timeout_hit_c = (cnt == CNT_W'(TIMEOUT - 1));
    assign gap_done_c    = (cnt == CNT_W'(GAP_CYCLES - 1));
    assign sol_set_c     = sol_req & enable;
    assign bb_set_c      = bb_req & enable;
    assign sol_clr_c     = (state == START) & ~grant_bb;
    assign bb_clr_c      = (state == START) & grant_bb;
    assign tmo_evt_c     = (state == WAIT) & ~adc_data_val & timeout_hit_c;

    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sol_pend || bb_pend) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT:    if (adc_data_val || timeout_hit_c) state_nxt = GAP;
            GAP:     if (gap_done_c) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shared counter: WAIT timeout, then GAP length
    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            cnt <= '0;
        end else begin
            case (state)
                WAIT:    cnt <= (state_nxt == GAP) ? '0 : cnt + CNT_W'(1);
                GAP:     cnt <= cnt + CNT_W'(1);
                default: cnt <= '0;
            endcase
        end
    end

    // A request coinciding with its own grant clear re-arms the flag
    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            sol_pend <= 1'b0;
            bb_pend  <= 1'b0;
            sol_ovr  <= 1'b0;
            bb_ovr   <= 1'b0;
        end else begin
            sol_pend <= sol_set_c | (sol_pend & ~sol_clr_c);
            bb_pend  <= bb_set_c | (bb_pend & ~bb_clr_c);
            if (sol_set_c && sol_pend && !sol_clr_c) sol_ovr <= 1'b1;
            else if (clr_err)                        sol_ovr <= 1'b0;
            if (bb_set_c && bb_pend && !bb_clr_c)    bb_ovr <= 1'b1;
            else if (clr_err)                        bb_ovr <= 1'b0;
        end
    end

    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            adc_convert <= 1'b0;
            busy        <= 1'b0;
            grant_bb    <= 1'b0;
            last_bb     <= 1'b1;
            timeout_err <= 1'b0;
        end else begin
            adc_convert <= (state_nxt == START);
            busy        <= (state_nxt != IDLE);
            if (state == IDLE && state_nxt == START) begin
                grant_bb <= grant_bb_c;
                last_bb  <= grant_bb_c;
            end
            if (tmo_evt_c)    timeout_err <= 1'b1;
            else if (clr_err) timeout_err <= 1'b0;
        end
    end

    assign convert_slow = grant_bb;

    // Result routing; strobes outside WAIT are ignored
    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            sol_data <= '0;
            sol_val  <= 1'b0;
            bb_data  <= '0;
            bb_val   <= 1'b0;
        end else begin
            sol_val <= 1'b0;
            bb_val  <= 1'b0;
            if (state == WAIT && adc_data_val) begin
                if (grant_bb) begin
                    bb_data <= adc_data;
                    bb_val  <= 1'b1;
                end else begin
                    sol_data <= adc_data;
                    sol_val  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_conv_sched.sv
// Scoreboard bench for adc_conv_sched: directed requests, an ADC response model,
// and a monitor that checks every start pulse and result strobe against queued expectations.
module tb_adc_conv_sched;

    localparam int unsigned GAP = 40;
    localparam int unsigned TMO = 1023;
    localparam int          LAT = 60;

    logic        tx_clk       = 1'b0;
    logic        tx_rst_n     = 1'b0;
    logic        enable       = 1'b1;
    logic        sol_req      = 1'b0;
    logic        bb_req       = 1'b0;
    logic        clr_err      = 1'b0;
    logic [11:0] adc_data     = '0;
    logic        adc_data_val = 1'b0;
    logic        adc_convert;
    logic        convert_slow;
    logic [11:0] sol_data;
    logic        sol_val;
    logic [11:0] bb_data;
    logic        bb_val;
    logic        busy;
    logic        sol_ovr;
    logic        bb_ovr;
    logic        timeout_err;

    adc_conv_sched #(.GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
        .tx_clk(tx_clk), .tx_rst_n(tx_rst_n), .enable(enable),
        .sol_req(sol_req), .bb_req(bb_req), .clr_err(clr_err),
        .adc_data(adc_data), .adc_data_val(adc_data_val),
        .adc_convert(adc_convert), .convert_slow(convert_slow),
        .sol_data(sol_data), .sol_val(sol_val),
        .bb_data(bb_data), .bb_val(bb_val), .busy(busy),
        .sol_ovr(sol_ovr), .bb_ovr(bb_ovr), .timeout_err(timeout_err)
    );

    always #5 tx_clk = ~tx_clk;

    int cyc = 0;
    always @(posedge tx_clk) cyc <= cyc + 1;

    typedef struct { logic slow; int cyc; } conv_t;
    typedef struct { logic bb; logic [11:0] data; int cyc; } res_t;

    conv_t       conv_q[$];
    res_t        res_q[$];
    logic [11:0] mdata_q[$];
    int          checks = 0;
    int          passed = 0;
    logic        withhold = 1'b0;
    int          stray_cnt = 0;
    int          stray_seen = 0;
    int          last_val_cyc = -1000;
    conv_t       mc;
    res_t        mr;
    logic [11:0] md;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                      name, act, act, exp, exp, cyc);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge tx_clk);
            #1;
        end
    endtask

    task automatic pulse(input logic s, input logic b, input int at);
        wait_cyc(at);
        sol_req = s;
        bb_req  = b;
        @(posedge tx_clk);
        #1;
        sol_req = 1'b0;
        bb_req  = 1'b0;
    endtask

    task automatic push_conv(input logic slow, input int at);
        conv_t c;
        c.slow = slow;
        c.cyc  = at;
        conv_q.push_back(c);
    endtask

    task automatic push_res(input logic bb, input logic [11:0] d, input int at);
        res_t r;
        r.bb   = bb;
        r.data = d;
        r.cyc  = at;
        res_q.push_back(r);
        mdata_q.push_back(d);
    endtask

    // Monitor: every start pulse and every result strobe must match a queued expectation
    always @(negedge tx_clk) begin
        if (tx_rst_n) begin
            if (adc_convert) begin
                if (conv_q.size() == 0) chk("unexpected_start", 1, 0);
                else begin
                    mc = conv_q.pop_front();
                    chk("start_slow", int'(convert_slow), int'(mc.slow));
                    chk("start_cycle", cyc, mc.cyc);
                    chk("start_spacing", int'(cyc - last_val_cyc >= int'(GAP) + 1), 1);
                end
            end
            if (sol_val || bb_val) begin
                if (res_q.size() == 0) chk("unexpected_val", 1, 0);
                else begin
                    mr = res_q.pop_front();
                    chk("val_bb_chan", int'(bb_val), int'(mr.bb));
                    chk("val_sol_chan", int'(sol_val), int'(!mr.bb));
                    chk("val_data", int'(bb_val ? bb_data : sol_data), int'(mr.data));
                    chk("val_cycle", cyc, mr.cyc);
                end
                last_val_cyc = cyc;
            end
        end
    end

    // ADC model: answers a start pulse LAT cycles later unless withheld
    always begin
        @(negedge tx_clk);
        if (stray_cnt != stray_seen) begin
            stray_seen = stray_cnt;
            @(posedge tx_clk);
            #1;
            adc_data     = 12'hFFF;
            adc_data_val = 1'b1;
            @(posedge tx_clk);
            #1;
            adc_data_val = 1'b0;
        end else if (adc_convert && tx_rst_n && !withhold) begin
            if (mdata_q.size() == 0) begin
                chk("model_data_avail", 0, 1);
                md = 12'h000;
            end else md = mdata_q.pop_front();
            repeat (LAT) @(posedge tx_clk);
            #1;
            adc_data     = md;
            adc_data_val = 1'b1;
            @(posedge tx_clk);
            #1;
            adc_data_val = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation ran past its time limit");
        $fatal(1);
    end

    initial begin
        wait_cyc(3);
        chk("rst_busy", int'(busy), 0);
        chk("rst_convert", int'(adc_convert), 0);
        chk("rst_slow", int'(convert_slow), 0);
        chk("rst_data", int'({sol_data, bb_data}), 0);
        chk("rst_flags", int'({sol_val, bb_val, sol_ovr, bb_ovr, timeout_err}), 0);
        wait_cyc(5);
        tx_rst_n = 1'b1;

        // Single SOL request
        push_conv(1'b0, 12);
        push_res(1'b0, 12'h5A3, 73);
        pulse(1'b1, 1'b0, 10);
        wait_cyc(74);
        chk("single_sol_data", int'(sol_data), 'h5A3);
        chk("single_sol_val_1cyc", int'(sol_val), 0);
        wait_cyc(120);
        chk("single_idle_busy", int'(busy), 0);
        chk("single_bb_data", int'(bb_data), 0);

        // Fresh reset so the tie-break starts from its reset state
        wait_cyc(130);
        tx_rst_n = 1'b0;
        wait_cyc(133);
        tx_rst_n = 1'b1;

        // Simultaneous requests: SOL first, BB follows after the gap
        push_conv(1'b0, 202);
        push_conv(1'b1, 304);
        push_res(1'b0, 12'hA11, 263);
        push_res(1'b1, 12'hB22, 365);
        pulse(1'b1, 1'b1, 200);
        wait_cyc(250);
        chk("sim_busy_wait", int'(busy), 1);
        wait_cyc(410);
        chk("sim_sol_data", int'(sol_data), 'hA11);
        chk("sim_bb_data", int'(bb_data), 'hB22);

        // Fairness: both kept pending, requests re-issued after each result
        for (int k = 0; k < 6; k++) begin
            push_conv(1'(k % 2), 452 + 102 * k);
            push_res(1'(k % 2), 12'(12'h100 + k), 452 + 102 * k + 61);
        end
        pulse(1'b1, 1'b1, 450);
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) pulse(1'b1, 1'b0, 452 + 102 * k + 62);
            else            pulse(1'b0, 1'b1, 452 + 102 * k + 62);
        end
        wait_cyc(1070);
        chk("fair_sol_ovr", int'(sol_ovr), 0);
        chk("fair_bb_ovr", int'(bb_ovr), 0);
        chk("fair_idle", int'(busy), 0);

        // Overrun: two BB pulses while SOL is waiting
        push_conv(1'b0, 1102);
        push_conv(1'b1, 1204);
        push_res(1'b0, 12'h0C3, 1163);
        push_res(1'b1, 12'h0B4, 1265);
        pulse(1'b1, 1'b0, 1100);
        pulse(1'b0, 1'b1, 1110);
        chk("ovr_not_yet", int'(bb_ovr), 0);
        pulse(1'b0, 1'b1, 1120);
        wait_cyc(1125);
        chk("ovr_bb_set", int'(bb_ovr), 1);
        chk("ovr_sol_clear", int'(sol_ovr), 0);
        wait_cyc(1320);
        chk("ovr_sticky", int'(bb_ovr), 1);
        clr_err = 1'b1;
        wait_cyc(1321);
        clr_err = 1'b0;
        wait_cyc(1322);
        chk("ovr_cleared", int'(bb_ovr), 0);

        // Stray data strobe in IDLE must be ignored
        wait_cyc(1330);
        stray_cnt++;
        wait_cyc(1335);
        chk("stray_sol_data", int'(sol_data), 'h0C3);
        chk("stray_bb_data", int'(bb_data), 'h0B4);

        // Requests with enable low are dropped
        enable = 1'b0;
        pulse(1'b1, 1'b1, 1342);
        wait_cyc(1350);
        enable = 1'b1;
        wait_cyc(1360);
        chk("disabled_no_busy", int'(busy), 0);

        // Timeout: model withholds the strobe
        withhold = 1'b1;
        push_conv(1'b0, 1402);
        pulse(1'b1, 1'b0, 1400);
        wait_cyc(2425);
        chk("tmo_not_yet", int'(timeout_err), 0);
        wait_cyc(2426);
        chk("tmo_set", int'(timeout_err), 1);
        wait_cyc(2465);
        chk("tmo_gap_busy", int'(busy), 1);
        wait_cyc(2466);
        chk("tmo_idle", int'(busy), 0);
        chk("tmo_sol_data_kept", int'(sol_data), 'h0C3);
        withhold = 1'b0;
        wait_cyc(2470);
        clr_err = 1'b1;
        wait_cyc(2471);
        clr_err = 1'b0;
        wait_cyc(2472);
        chk("tmo_cleared", int'(timeout_err), 0);
        push_conv(1'b0, 2482);
        push_res(1'b0, 12'h3C1, 2543);
        pulse(1'b1, 1'b0, 2480);

        // Reset during WAIT with a BB request pending
        wait_cyc(2600);
        withhold = 1'b1;
        push_conv(1'b0, 2702);
        pulse(1'b1, 1'b0, 2700);
        pulse(1'b0, 1'b1, 2710);
        wait_cyc(2720);
        tx_rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_sol_data", int'(sol_data), 0);
        chk("arst_flags", int'({adc_convert, convert_slow, sol_val, bb_val, sol_ovr, bb_ovr, timeout_err}), 0);
        wait_cyc(2725);
        tx_rst_n = 1'b1;
        withhold = 1'b0;
        wait_cyc(2735);
        chk("arst_pend_cleared", int'(busy), 0);
        push_conv(1'b0, 2742);
        push_conv(1'b1, 2844);
        push_res(1'b0, 12'h7E2, 2803);
        push_res(1'b1, 12'h4D5, 2905);
        pulse(1'b1, 1'b1, 2740);
        wait_cyc(2960);
        chk("final_busy", int'(busy), 0);
        chk("final_conv_q", conv_q.size(), 0);
        chk("final_res_q", res_q.size(), 0);
        chk("final_model_q", mdata_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
